// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial word receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_rx_holdbuf.sv
// One-entry valid/ready output buffer; drops a new word and flags overrun when full and stalled.
module serial_rx_holdbuf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        // A draining buffer can accept the new word in the same cycle.
        if (!data_valid || data_ready) begin
          data_out   <= word;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// Strobe-qualified serial frame receiver (start, WIDTH data LSB first, optional even parity, stop).
// Parity bit support is compiled in with SERIAL_RX_PARITY_EN.
module serial_word_rx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  rx_state_e        state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic             frame_err_n;
  logic             word_good;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_bad, par_bad_n;
  logic             parity_err_n;
`endif

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    frame_err_n = 1'b0;
    word_good   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_n    = par_bad;
    parity_err_n = 1'b0;
`endif
    if (bit_valid) begin
      unique case (state)
        RX_IDLE: begin
          if (bit_in == START_BIT) begin
            bit_cnt_n = '0;
            state_n   = RX_DATA;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_n = 1'b0;
`endif
          end
        end
        RX_DATA: begin
          shreg_n   = {bit_in, shreg[WIDTH-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_n = RX_PARITY;
`else
            state_n = RX_STOP;
`endif
          end
        end
        RX_PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
          par_bad_n = (bit_in != ^shreg);
          state_n   = RX_STOP;
`else
          state_n   = RX_IDLE;
`endif
        end
        RX_STOP: begin
          state_n = RX_IDLE;
          // Framing error wins over parity error; at most one pulse per frame.
          if (bit_in == START_BIT) begin
            frame_err_n = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          end else if (par_bad) begin
            parity_err_n = 1'b1;
`endif
          end else begin
            word_good = 1'b1;
          end
        end
        default: state_n = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      frame_err <= frame_err_n;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_n;
      parity_err <= parity_err_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != RX_IDLE);

  serial_rx_holdbuf #(
    .WIDTH (WIDTH)
  ) u_holdbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (word_good),
    .word       (shreg_n),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule
